// File: rtl/rr_arb32_pkg.sv
// Shared definitions for the 32-way round-robin arbiter: sizes, FSM states
// and the index-to-one-hot helper used to build the registered select.
package rr_arb32_pkg;

   localparam int ARB_N     = 32;
   localparam int ARB_IDX_W = 5;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_e;

   function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
      logic [ARB_N-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick32.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping from 31 back to 0.
module rr_pick32
   import rr_arb32_pkg::*;
(
   input  logic [ARB_N-1:0]     req,
   input  logic [ARB_IDX_W-1:0] ptr,
   output logic                 any,
   output logic [ARB_IDX_W-1:0] idx
);

   logic [ARB_N-1:0]     rot;
   logic [ARB_IDX_W-1:0] off;
   logic                 found;

   always_comb begin
      // Rotating right by ptr puts requester ptr at bit 0, so the lowest
      // set bit of rot is the next requester in round-robin order.
      rot   = ARB_N'({req, req} >> ptr);
      off   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < ARB_N; i++) begin
         if (rot[i] && !found) begin
            off   = ARB_IDX_W'(i);
            found = 1'b1;
         end
      end
      any = found;
      idx = ptr + off;
   end

endmodule

// File: rtl/rr_arb32.sv
// Round-robin arbiter for 32 requesters with a per-tenure hold limit,
// registered index, one-hot select and preemption pulse.
module rr_arb32
   import rr_arb32_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [ARB_N-1:0]     req,
   output logic                 gnt_valid,
   output logic [ARB_IDX_W-1:0] gnt_idx,
   output logic [ARB_N-1:0]     gnt_onehot,
   output logic                 preempt
);

   localparam int unsigned     HCW       = $clog2(MAX_HOLD + 1);
   localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);

   arb_state_e           state_q,      state_d;
   logic [ARB_IDX_W-1:0] ptr_q,        ptr_d;
   logic [HCW-1:0]       hold_cnt_q,   hold_cnt_d;
   logic                 gnt_valid_q,  gnt_valid_d;
   logic [ARB_IDX_W-1:0] gnt_idx_q,    gnt_idx_d;
   logic [ARB_N-1:0]     gnt_onehot_q, gnt_onehot_d;
   logic                 preempt_q,    preempt_d;

   logic                 pick_any;
   logic [ARB_IDX_W-1:0] pick_idx;

   rr_pick32 u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      hold_cnt_d   = hold_cnt_q;
      gnt_valid_d  = gnt_valid_q;
      gnt_idx_d    = gnt_idx_q;
      gnt_onehot_d = gnt_onehot_q;
      preempt_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (en && pick_any) begin
               state_d      = GRANT;
               gnt_idx_d    = pick_idx;
               hold_cnt_d   = '0;
               gnt_valid_d  = 1'b1;
               gnt_onehot_d = idx_to_onehot(pick_idx);
            end
         end
         GRANT: begin
            // Release wins over the hold limit, so preempt only fires when
            // the owner is still requesting on its last allowed cycle.
            if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST)) begin
               state_d      = IDLE;
               ptr_d        = gnt_idx_q + 1'b1;
               gnt_valid_d  = 1'b0;
               gnt_onehot_d = '0;
               preempt_d    = req[gnt_idx_q];
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d   = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         hold_cnt_q   <= '0;
         gnt_valid_q  <= 1'b0;
         gnt_idx_q    <= '0;
         gnt_onehot_q <= '0;
         preempt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         hold_cnt_q   <= hold_cnt_d;
         gnt_valid_q  <= gnt_valid_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_onehot_q <= gnt_onehot_d;
         preempt_q    <= preempt_d;
      end
   end

   assign gnt_valid  = gnt_valid_q;
   assign gnt_idx    = gnt_idx_q;
   assign gnt_onehot = gnt_onehot_q;
   assign preempt    = preempt_q;

endmodule

// File: tb/tb_rr_arb32.sv
// Self-checking bench for rr_arb32: two instances (hold limits 2 and 16)
// share stimulus and are compared every cycle against a tenure-level model.
module tb_rr_arb32;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [31:0] req;

   logic        a_valid, a_pre, b_valid, b_pre;
   logic [4:0]  a_idx, b_idx;
   logic [31:0] a_oh, b_oh;

   int errors = 0;
   int checks = 0;

   // Model state: owner (-1 when idle), cycles granted in this tenure,
   // search start, last owner and preempt flag, one slot per instance.
   int m_owner  [2];
   int m_cycles [2];
   int m_ptr    [2];
   int m_idx    [2];
   bit m_pre    [2];
   int m_hold   [2] = '{2, 16};

   typedef struct {
      logic [31:0] req;
      logic        en;
      logic        valid;
      logic [4:0]  idx;
      logic        pre;
   } vec_t;

   vec_t tbl [10];

   rr_arb32 #(.MAX_HOLD(2)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req        (req),
      .gnt_valid  (a_valid),
      .gnt_idx    (a_idx),
      .gnt_onehot (a_oh),
      .preempt    (a_pre)
   );

   rr_arb32 #(.MAX_HOLD(16)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req        (req),
      .gnt_valid  (b_valid),
      .gnt_idx    (b_idx),
      .gnt_onehot (b_oh),
      .preempt    (b_pre)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k]  = -1;
         m_cycles[k] = 0;
         m_ptr[k]    = 0;
         m_idx[k]    = 0;
         m_pre[k]    = 1'b0;
      end
   endtask

   task automatic model_step(input logic [31:0] r, input logic e);
      for (int k = 0; k < 2; k++) begin
         if (m_owner[k] < 0) begin
            m_pre[k] = 1'b0;
            if (e && r != 0) begin
               for (int s = 0; s < 32; s++) begin
                  if (r[(m_ptr[k] + s) % 32]) begin
                     m_owner[k] = (m_ptr[k] + s) % 32;
                     break;
                  end
               end
               m_idx[k]    = m_owner[k];
               m_cycles[k] = 1;
            end
         end else if (!r[m_owner[k]]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 32;
            m_owner[k] = -1;
            m_pre[k]   = 1'b0;
         end else if (m_cycles[k] == m_hold[k]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 32;
            m_owner[k] = -1;
            m_pre[k]   = 1'b1;
         end else begin
            m_cycles[k]++;
         end
      end
   endtask

   task automatic check_model();
      logic        v;
      logic [31:0] exp_oh;
      string       nm;
      for (int k = 0; k < 2; k++) begin
         nm     = (k == 0) ? "A" : "B";
         v      = (m_owner[k] >= 0);
         exp_oh = v ? (32'd1 << m_idx[k]) : 32'd0;
         check({nm, ".gnt_valid"},  32'((k == 0) ? a_valid : b_valid), 32'(v));
         check({nm, ".gnt_idx"},    32'((k == 0) ? a_idx   : b_idx),   32'(m_idx[k]));
         check({nm, ".gnt_onehot"}, (k == 0) ? a_oh : b_oh,            exp_oh);
         check({nm, ".preempt"},    32'((k == 0) ? a_pre   : b_pre),   32'(m_pre[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(req, en);
      #1;
      check_model();
   endtask

   // Called just after a tick: assert and release well away from posedge.
   task automatic do_reset();
      req = '0;
      en  = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_model();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nv;
      int na;
      int nb;
      logic [31:0] r;

      for (int i = 0; i < 10; i++) tbl[i].req = 32'h8000_0003;
      for (int i = 0; i < 10; i++) tbl[i].en  = 1'b1;
      tbl[0].valid = 1; tbl[0].idx = 0;  tbl[0].pre = 0;
      tbl[1].valid = 1; tbl[1].idx = 0;  tbl[1].pre = 0;
      tbl[2].valid = 0; tbl[2].idx = 0;  tbl[2].pre = 1;
      tbl[3].valid = 1; tbl[3].idx = 1;  tbl[3].pre = 0;
      tbl[4].valid = 1; tbl[4].idx = 1;  tbl[4].pre = 0;
      tbl[5].valid = 0; tbl[5].idx = 1;  tbl[5].pre = 1;
      tbl[6].valid = 1; tbl[6].idx = 31; tbl[6].pre = 0;
      tbl[7].valid = 1; tbl[7].idx = 31; tbl[7].pre = 0;
      tbl[8].valid = 0; tbl[8].idx = 31; tbl[8].pre = 1;
      tbl[9].valid = 1; tbl[9].idx = 0;  tbl[9].pre = 0;

      // Reset and single request
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 32'h0000_0004;
      model_reset();
      #12;
      check_model();
      rst_n = 1'b1;
      tick();
      check("single.valid",  32'(a_valid), 32'd1);
      check("single.idx",    32'(a_idx),   32'd2);
      check("single.onehot", a_oh,         32'h0000_0004);
      req = '0;
      tick();
      check("single.release", 32'(a_valid), 32'd0);

      // Rotation with hold limit 2 (instance A)
      do_reset();
      for (int i = 0; i < 10; i++) begin
         req = tbl[i].req;
         en  = tbl[i].en;
         tick();
         check($sformatf("rot[%0d].valid", i),   32'(a_valid), 32'(tbl[i].valid));
         check($sformatf("rot[%0d].idx", i),     32'(a_idx),   32'(tbl[i].idx));
         check($sformatf("rot[%0d].preempt", i), 32'(a_pre),   32'(tbl[i].pre));
      end

      // Wrap-around after owner 31
      do_reset();
      req = 32'h8000_0000;
      tick();
      check("wrap.first", 32'(a_idx), 32'd31);
      req = '0;
      tick();
      check("wrap.released", 32'(a_valid), 32'd0);
      req = 32'h8000_0001;
      tick();
      check("wrap.a_idx", 32'(a_idx), 32'd0);
      check("wrap.b_idx", 32'(b_idx), 32'd0);

      // Enable gating with ptr moved to 5
      do_reset();
      req = 32'h0000_0010;
      tick();
      req = '0;
      tick();
      en  = 1'b0;
      req = 32'hFFFF_FFFF;
      repeat (3) begin
         tick();
         check("en_off.a_valid", 32'(a_valid), 32'd0);
         check("en_off.b_valid", 32'(b_valid), 32'd0);
      end
      en = 1'b1;
      tick();
      check("en_on.a_idx", 32'(a_idx), 32'd5);
      check("en_on.b_idx", 32'(b_idx), 32'd5);
      en = 1'b0;
      na = 0;
      nb = 0;
      repeat (20) begin
         tick();
         if (a_valid) na++;
         if (b_valid) nb++;
      end
      check("en_mid.a_rest",   32'(na),      32'd1);
      check("en_mid.b_rest",   32'(nb),      32'd15);
      check("en_mid.a_valid",  32'(a_valid), 32'd0);
      check("en_mid.b_valid",  32'(b_valid), 32'd0);

      // Preemption boundary with hold limit 16 (instance B)
      do_reset();
      req = 32'h0000_0080;
      tick();
      nv = 0;
      for (int i = 0; i < 40 && b_valid; i++) begin
         nv++;
         tick();
      end
      check("hold16.cycles",  32'(nv),    32'd16);
      check("hold16.preempt", 32'(b_pre), 32'd1);
      tick();
      check("hold16.regrant", 32'(b_valid), 32'd1);
      check("hold16.idx",     32'(b_idx),   32'd7);
      check("hold16.pulse",   32'(b_pre),   32'd0);

      // Asynchronous reset mid-tenure, with ptr previously advanced to 21
      do_reset();
      req = 32'h0010_0000;
      tick();
      req = '0;
      tick();
      req = 32'h0000_1000;
      tick();
      tick();
      check("arst.pre_a_valid", 32'(a_valid), 32'd1);
      check("arst.pre_b_idx",   32'(b_idx),   32'd12);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst.a_onehot", a_oh,          32'd0);
      check("arst.b_onehot", b_oh,          32'd0);
      check("arst.b_valid",  32'(b_valid),  32'd0);
      check("arst.a_pre",    32'(a_pre),    32'd0);
      #2;
      rst_n = 1'b1;
      req = 32'h0200_1000;
      tick();
      check("arst.a_idx", 32'(a_idx), 32'd12);
      check("arst.b_idx", 32'(b_idx), 32'd12);
      tick();
      check("arst.no_pre", 32'(b_pre), 32'd0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
               0: r = '0;
               1: r = 32'd1 << $urandom_range(0, 31);
               2: r = $urandom & $urandom & $urandom;
               3: r = $urandom;
               default: r = ~($urandom & $urandom);
            endcase
            req = r;
         end
         en = ($urandom_range(0, 7) != 0);
         tick();
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
